// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
// -------------
// Multi-cycle sequencer that issues every access to a 16x16 register file.
// Each accepted instruction takes four cycles: IDLE (accept), READ (drive the
// read addresses, latch A/B), EXEC (compute result and flags), WB (write back
// through C/Caddr/Load, or pulse clear for CLR).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   instr_valid/instr_ready/instr
//                   instruction issue handshake; instr = {op, dest, srcA, srcB}
//                   with srcA/srcB doubling as an 8-bit immediate for LDI
//   Aaddr, Baddr    register file read addresses (held from accept)
//   A, B            register file read data, combinational from Aaddr/Baddr
//   Caddr, C, Load  register file write port, Load is a one-cycle pulse
//   clear           register file clear, one-cycle pulse
//   done            one-cycle completion pulse, once per instruction
//   result          last computed result, held
//   flag_z/c/v      zero/carry/overflow of the last arithmetic or logic op
//   illegal         sticky, set by any undefined opcode
//   state_dbg       current FSM state (IDLE=0, READ=1, EXEC=2, WB=3)
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready depends only on state (never on
// instr_valid), and instr is not looked at in any other cycle.

module reg_file_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [OP_W+3*ADDR_W-1:0]    instr,
    output logic [ADDR_W-1:0]           Aaddr,
    output logic [ADDR_W-1:0]           Baddr,
    input  logic [DATA_W-1:0]           A,
    input  logic [DATA_W-1:0]           B,
    output logic [ADDR_W-1:0]           Caddr,
    output logic [DATA_W-1:0]           C,
    output logic                        Load,
    output logic                        clear,
    output logic                        done,
    output logic [DATA_W-1:0]           result,
    output logic                        flag_z,
    output logic                        flag_c,
    output logic                        flag_v,
    output logic                        illegal,
    output logic [1:0]                  state_dbg
);

    localparam int INSTR_W = OP_W + 3 * ADDR_W;
    localparam int IMM_W   = 2 * ADDR_W;
    localparam int MSB     = DATA_W - 1;

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MOV = OP_W'(6);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(7);
    localparam logic [OP_W-1:0] OP_CLR = OP_W'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  opa, opb;

    logic [OP_W-1:0]    op;
    logic [ADDR_W-1:0]  dest;
    logic [IMM_W-1:0]   imm;
    logic               is_write;
    logic               is_flag_op;

    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  exec_res;
    logic               exec_z, exec_c, exec_v, exec_ill;

    // Instruction field decode from the latched instruction.
    assign op         = instr_q[INSTR_W-1 -: OP_W];
    assign dest       = instr_q[3*ADDR_W-1 -: ADDR_W];
    assign imm        = instr_q[IMM_W-1:0];
    assign is_write   = (op >= OP_ADD) && (op <= OP_LDI);
    assign is_flag_op = (op >= OP_ADD) && (op <= OP_XOR);

    assign state_dbg  = state;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes decode straight from state, so the asynchronous return to IDLE
    // drops Load/clear/done immediately and an abandoned instruction never
    // writes or clears.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        Load        = 1'b0;
        clear       = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = READ;
                end
            end
            READ: state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB: begin
                Load      = is_write;
                clear     = (op == OP_CLR);
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- ALU
    // Non-updating ops (NOP, CLR, illegal) fall through with the held result
    // and flags, so the EXEC edge can load these values unconditionally.
    always_comb begin
        exec_res = result;
        exec_z   = flag_z;
        exec_c   = flag_c;
        exec_v   = flag_v;
        exec_ill = illegal;
        sum      = {1'b0, opa} + {1'b0, opb};
        diff     = {1'b0, opa} + {1'b0, ~opb} + {{DATA_W{1'b0}}, 1'b1};
        case (op)
            OP_NOP: ;
            OP_ADD: begin
                exec_res = sum[DATA_W-1:0];
                exec_c   = sum[DATA_W];
                exec_v   = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
            end
            OP_SUB: begin
                // Carry out of A + ~B + 1 is set when no borrow occurred.
                exec_res = diff[DATA_W-1:0];
                exec_c   = diff[DATA_W];
                exec_v   = (opa[MSB] != opb[MSB]) && (diff[MSB] != opa[MSB]);
            end
            OP_AND: begin
                exec_res = opa & opb;
                exec_c   = 1'b0;
                exec_v   = 1'b0;
            end
            OP_OR: begin
                exec_res = opa | opb;
                exec_c   = 1'b0;
                exec_v   = 1'b0;
            end
            OP_XOR: begin
                exec_res = opa ^ opb;
                exec_c   = 1'b0;
                exec_v   = 1'b0;
            end
            OP_MOV: exec_res = opa;
            OP_LDI: exec_res = {{(DATA_W-IMM_W){1'b0}}, imm};
            OP_CLR: ;
            default: exec_ill = 1'b1;
        endcase
        if (is_flag_op) begin
            exec_z = (exec_res == '0);
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            opa     <= '0;
            opb     <= '0;
            Aaddr   <= '0;
            Baddr   <= '0;
            Caddr   <= '0;
            C       <= '0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        // Read addresses come straight from the incoming
                        // instruction so they are stable for all of READ.
                        instr_q <= instr;
                        Aaddr   <= instr[2*ADDR_W-1 -: ADDR_W];
                        Baddr   <= instr[ADDR_W-1:0];
                    end
                end
                READ: begin
                    opa <= A;
                    opb <= B;
                end
                EXEC: begin
                    result  <= exec_res;
                    flag_z  <= exec_z;
                    flag_c  <= exec_c;
                    flag_v  <= exec_v;
                    illegal <= exec_ill;
                    Caddr   <= dest;
                    C       <= exec_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
module tb_reg_file_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [3:0]  Aaddr, Baddr, Caddr;
  logic [15:0] A, B, C, result;
  logic        Load, clear, done, flag_z, flag_c, flag_v, illegal;
  logic [1:0]  state_dbg;

  reg_file_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .Aaddr(Aaddr), .Baddr(Baddr), .A(A), .B(B),
    .Caddr(Caddr), .C(C), .Load(Load), .clear(clear), .done(done),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- register file
  logic [15:0] rf_mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign A = rf_mem[Aaddr];
  assign B = rf_mem[Baddr];

  always @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (Load) begin
      rf_mem[Caddr] <= C;
    end else if (pre_we) begin
      rf_mem[pre_addr] <= pre_data;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: on acceptance the whole instruction outcome is worked
  // out from the shadow register contents; the only timing knowledge is
  // "accept, then READ, EXEC, WB", i.e. the outcome shows three cycles later.
  logic [15:0] exp_q[$];
  initial begin
    logic [15:0] sh [16];
    bit          busy;
    int          age;
    logic [15:0] m_res;
    bit          m_z, m_c, m_v, m_ill;
    logic [3:0]  p_dest, p_sa, p_sb;
    logic [15:0] p_res;
    bit          p_wr, p_clr, p_upd_res, p_upd_fl, p_ill, p_z, p_c, p_v;
    bit          e_load, e_clr, e_done;
    for (int i = 0; i < 16; i++) sh[i] = '0;
    busy = 0; age = 0; m_res = '0; m_z = 0; m_c = 0; m_v = 0; m_ill = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; m_res = '0; m_z = 0; m_c = 0; m_v = 0; m_ill = 0;
        check("rst_ready", instr_ready, 1);
        check("rst_load", Load, 0);
        check("rst_clear", clear, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {flag_z, flag_c, flag_v}, 0);
        check("rst_illegal", illegal, 0);
        continue;
      end
      e_load = 0; e_clr = 0; e_done = 0;
      if (busy && age == 1) begin
        check("read_Aaddr", Aaddr, p_sa);
        check("read_Baddr", Baddr, p_sb);
      end
      if (busy && age == 3) begin
        if (p_upd_res) m_res = p_res;
        if (p_upd_fl) begin m_z = p_z; m_c = p_c; m_v = p_v; end
        if (p_ill) m_ill = 1;
        e_load = p_wr; e_clr = p_clr; e_done = 1;
        check("wb_Caddr", Caddr, p_dest);
        check("wb_C", C, m_res);
      end
      check("instr_ready", instr_ready, !busy);
      check("Load", Load, e_load);
      check("clear", clear, e_clr);
      check("done", done, e_done);
      check("result", result, m_res);
      check("flags", {flag_z, flag_c, flag_v}, {m_z, m_c, m_v});
      check("illegal", illegal, m_ill);
      // advance to the coming rising edge
      if (busy) begin
        if (age == 3) begin
          if (p_wr) sh[p_dest] = m_res;
          if (p_clr) for (int i = 0; i < 16; i++) sh[i] = '0;
          busy = 0;
        end else begin
          age++;
        end
      end else if (instr_valid) begin
        logic [15:0] a, b;
        int sa_i, sb_i, wide;
        p_dest = instr[11:8]; p_sa = instr[7:4]; p_sb = instr[3:0];
        a = sh[p_sa]; b = sh[p_sb];
        sa_i = int'($signed(a)); sb_i = int'($signed(b));
        p_wr = 0; p_clr = 0; p_upd_res = 0; p_upd_fl = 0; p_ill = 0;
        p_res = '0; p_c = 0; p_v = 0;
        case (instr[15:12])
          4'd0: ;
          4'd1: begin
            p_res = a + b; p_c = (int'(a) + int'(b)) > 65535;
            wide = sa_i + sb_i; p_v = (wide > 32767) || (wide < -32768);
            p_upd_res = 1; p_upd_fl = 1; p_wr = 1;
          end
          4'd2: begin
            p_res = a - b; p_c = (a >= b);
            wide = sa_i - sb_i; p_v = (wide > 32767) || (wide < -32768);
            p_upd_res = 1; p_upd_fl = 1; p_wr = 1;
          end
          4'd3: begin p_res = a & b; p_upd_res = 1; p_upd_fl = 1; p_wr = 1; end
          4'd4: begin p_res = a | b; p_upd_res = 1; p_upd_fl = 1; p_wr = 1; end
          4'd5: begin p_res = a ^ b; p_upd_res = 1; p_upd_fl = 1; p_wr = 1; end
          4'd6: begin p_res = a; p_upd_res = 1; p_wr = 1; end
          4'd7: begin p_res = {8'h00, instr[7:0]}; p_upd_res = 1; p_wr = 1; end
          4'd8: p_clr = 1;
          default: p_ill = 1;
        endcase
        p_z = (p_res == 16'h0000);
        busy = 1; age = 1;
      end
      if (pre_we) sh[pre_addr] = pre_data;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic preload(input logic [3:0] ad, input logic [15:0] da);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = ad; pre_data = da;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Returns at #1 after the accepting edge; instr_valid stays high if hold.
  task automatic issue(input logic [15:0] w, input bit hold);
    bit ok;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = w;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_seen", instr_ready, 1);
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    bit ok;
    cyc = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin ok = 1; break; end
    end
    if (!ok) check("done_seen", done, 1);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int cyc, low;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);
    check("post_rst_state", state_dbg, 0);

    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));

    // LDI R1,0x34 ; LDI R2,0x12
    issue(16'h7134, 0); wait_done(cyc);
    check("ldi1_latency", cyc, 3);
    check("ldi1_r1", rf_mem[1], 16'h0034);
    issue(16'h7212, 0); wait_done(cyc);
    check("ldi2_latency", cyc, 3);
    check("ldi2_r2", rf_mem[2], 16'h0012);

    // ADD R3,R1,R2 with signed overflow
    preload(4'd1, 16'h7FFF); preload(4'd2, 16'h0001);
    issue(16'h1312, 0); wait_done(cyc);
    check("add_r3", rf_mem[3], 16'h8000);
    check("add_zcv", {flag_z, flag_c, flag_v}, 3'b001);

    // SUB R4,R1,R1 then MOV R5,R4
    preload(4'd1, 16'h0005);
    issue(16'h2411, 0); wait_done(cyc);
    check("sub_r4", rf_mem[4], 16'h0000);
    check("sub_zcv", {flag_z, flag_c, flag_v}, 3'b110);
    preload(4'd5, 16'h1234);
    issue(16'h6540, 0); wait_done(cyc);
    check("mov_r5", rf_mem[5], 16'h0000);

    // back-to-back with instr_valid held high: LDI R1,1 ; ADD R1,R1,R1
    issue(16'h7101, 1);
    instr = 16'h1111;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) break;
      low++;
    end
    check("b2b_ready_low", low, 3);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done(cyc);
    check("b2b_r1", rf_mem[1], 16'h0002);

    // CLR after loading R0-R3, then an illegal opcode
    for (int i = 0; i < 4; i++) preload(4'(i), 16'(16'hA0 + i));
    issue(16'h8000, 0); wait_done(cyc);
    for (int i = 0; i < 16; i++) check("clr_rf", rf_mem[i], 16'h0000);
    issue(16'hF000, 0); wait_done(cyc);
    check("illegal_set", illegal, 1);
    issue(16'h7355, 0); wait_done(cyc);
    check("illegal_sticky", illegal, 1);
    check("ldi_after_illegal", rf_mem[3], 16'h0055);

    // reset during EXEC of ADD R6,R1,R2
    preload(4'd6, 16'hABCD);
    issue(16'h1612, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", instr_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    check("abort_r6", rf_mem[6], 16'hABCD);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 19);
      if (r <= 8) op = 4'(r);
      else if (r <= 16) op = 4'($urandom_range(1, 5));
      else op = 4'($urandom_range(9, 15));
      issue({op, 12'($urandom)}, 0);
      if ($urandom_range(0, 3) == 0) begin
        wait_done(cyc);
        if ($urandom_range(0, 1) == 1) preload(4'($urandom), 16'($urandom));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_done(cyc);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Multi-cycle sequencer that initiates all traffic into the 16x16 register file.
- Accepts one 16-bit instruction per valid/ready handshake and drives the register file read addresses.
- Latches the A/B operands the file returns, computes a result, then writes it back via C/Caddr/Load, or pulses the file's clear.
- Sits between instruction issue and the register file; the register file's A/B read path is combinational.

Parameters:
- DATA_W, 16, operand/result width; must match register file data width.
- ADDR_W, 4, register address width (16 registers).
- OP_W, 4, opcode width; instruction width = OP_W + 3*ADDR_W = 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept (high only in IDLE).
- instr  in  16  [15:12] op, [11:8] dest, [7:4] srcA, [3:0] srcB / [7:0] imm.
- Aaddr  out  4  register file A read address.
- Baddr  out  4  register file B read address.
- A  in  16  register file A read data (combinational from Aaddr).
- B  in  16  register file B read data.
- Caddr  out  4  write-back address.
- C  out  16  write-back data.
- Load  out  1  write enable, one-cycle pulse.
- clear  out  1  register file clear, one-cycle pulse.
- done  out  1  one-cycle completion pulse.
- result  out  16  last computed result (held).
- flag_z, flag_c, flag_v  out  1 each  zero/carry/overflow of last arithmetic or logic op.
- illegal  out  1  sticky; set by an undefined opcode.

Behaviour:
- Reset: state=IDLE. instruction/operand/result registers, Aaddr, Baddr, Caddr, C, result, flags and illegal all 0. Load, clear and done are forced low asynchronously. instr_ready=1 after reset release.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE. One instruction per 4 cycles.
- IDLE: instr_ready=1. When instr_valid&instr_ready at a rising edge, latch instr and go to READ. instr is ignored at all other times.
- READ: Aaddr=srcA, Baddr=srcB. At the closing edge, latch A and B into operand registers.
- EXEC: compute from the latched operands. result and flags update at the closing edge.
- WB:
  - Caddr=dest, C=result.
  - Load=1 for write-producing ops; clear=1 for CLR only.
  - done=1 for every instruction.
  - The register file captures the write at the edge that ends WB.
- Opcodes, 16-bit wrap-around arithmetic:
  - 0 NOP: no write; flags held.
  - 1 ADD: A+B; C=carry out; V=signed overflow.
  - 2 SUB: A-B, computed as A+~B+1; C=1 means no borrow; V=signed overflow.
  - 3 AND, 4 OR, 5 XOR: C=0, V=0.
  - 6 MOV: result=A; flags held.
  - 7 LDI: result={8'h00, imm}; flags held.
  - 8 CLR: clear=1 and Load=0 in WB; result and flags held.
  - 9-15: treated as NOP; set illegal.
- flag_z=(result==0) for ops 1-5 only.
- Load and clear are never high in the same cycle.
- Dependent back-to-back instructions: the next READ starts at least one cycle after the WB edge, so it always sees the written value. No forwarding is needed.
- dest=srcA (e.g. ADD R1,R1,R2) is legal; the operand is already latched before WB.
- instr_valid held high continuously: the next instruction is accepted in the IDLE cycle following WB.
- rst asserted mid-instruction: the instruction is abandoned with no write or clear. It returns to IDLE; the register file contents are untouched.

Test Plan:
- Reset then LDI R1,0x34 and LDI R2,0x12 (0x7134, 0x7212) -> Load pulses with Caddr=1,C=0x0034 then Caddr=2,C=0x0012. done pulse 3 cycles after each accept.
- Preload R1=0x7FFF, R2=0x0001; ADD R3,R1,R2 (0x1312) -> C=0x8000, Caddr=3; flag_v=1, flag_c=0, flag_z=0.
- Preload R1=0x0005; SUB R4,R1,R1 (0x2411) -> C=0x0000, flag_z=1, flag_c=1, flag_v=0. A following MOV R5,R4 writes 0x0000 to R5.
- Back-to-back with instr_valid stuck high: LDI R1,0x01 then ADD R1,R1,R1 -> R1=0x0002. instr_ready low for exactly 3 cycles between accepts.
- CLR (0x8000) after loading R0-R3 -> single clear pulse, Load=0. All registers read 0 afterwards. Then opcode 0xF000 -> no Load, illegal=1 and stays set.
- Assert rst during EXEC of ADD R6,R1,R2 -> Load never asserts, R6 unchanged. instr_ready=1 immediately after release.
